// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

   localparam int unsigned DEFAULT_DATA_W = 16;
   localparam int unsigned DEFAULT_N_REG  = 32;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by issue, cleared by either write port; set wins over clear.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned N_REG  = DEFAULT_N_REG,
   parameter int unsigned ADDR_W = clog2(N_REG)
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              set,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_a,
   input  logic [ADDR_W-1:0] clr_a_addr,
   input  logic              clr_b,
   input  logic [ADDR_W-1:0] clr_b_addr,
   output logic [N_REG-1:0]  busy
);

   logic [N_REG-1:0] busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      if (clr_a) busy_d[clr_a_addr] = 1'b0;
      if (clr_b) busy_d[clr_b_addr] = 1'b0;
      // A new producer issued in the same cycle outlives the old write.
      if (set)   busy_d[set_addr]   = 1'b1;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Two-write, N-read flip-flop register file with optional forwarding and a busy scoreboard.
module register_file_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEFAULT_DATA_W,
   parameter int unsigned N_REG    = DEFAULT_N_REG,
   parameter int unsigned N_RD     = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1,
   localparam int unsigned ADDR_W  = clog2(N_REG)
) (
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic                     we_a,
   input  logic [ADDR_W-1:0]        waddr_a,
   input  logic [DATA_W-1:0]        wdata_a,
   input  logic                     we_b,
   input  logic [ADDR_W-1:0]        waddr_b,
   input  logic [DATA_W-1:0]        wdata_b,
   input  logic [N_RD*ADDR_W-1:0]   raddr,
   output logic [N_RD*DATA_W-1:0]   rdata,
   input  logic                     issue_valid,
   input  logic [ADDR_W-1:0]        issue_addr,
   output logic [N_RD-1:0]          rd_busy,
   output logic                     stall
);

   logic [DATA_W-1:0] regs_q [N_REG];
   logic [N_REG-1:0]  busy;
   logic              wr_a, wr_b, set_en;

   // Effective enables: register 0 is neither writable nor trackable when hardwired.
   assign wr_a   = we_a && !(ZERO_REG != 0 && waddr_a == '0);
   assign wr_b   = we_b && !(ZERO_REG != 0 && waddr_b == '0);
   assign set_en = issue_valid && !(ZERO_REG != 0 && issue_addr == '0);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < int'(N_REG); i++) regs_q[i] <= '0;
      end else begin
         if (wr_a) regs_q[waddr_a] <= wdata_a;
         if (wr_b) regs_q[waddr_b] <= wdata_b;
      end
   end

   regfile_scoreboard #(
      .N_REG  (N_REG),
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk        (clk),
      .arst_n     (arst_n),
      .set        (set_en),
      .set_addr   (issue_addr),
      .clr_a      (wr_a),
      .clr_a_addr (waddr_a),
      .clr_b      (wr_b),
      .clr_b_addr (waddr_b),
      .busy       (busy)
   );

   always_comb begin
      rdata   = '0;
      rd_busy = '0;
      for (int i = 0; i < int'(N_RD); i++) begin
         logic [ADDR_W-1:0] addr;
         logic [DATA_W-1:0] word;
         logic              fwd;
         addr = raddr[i*ADDR_W +: ADDR_W];
         word = regs_q[addr];
         fwd  = 1'b0;
         if (BYPASS != 0) begin
            if (wr_b && waddr_b == addr) begin
               word = wdata_b;
               fwd  = 1'b1;
            end else if (wr_a && waddr_a == addr) begin
               word = wdata_a;
               fwd  = 1'b1;
            end
         end
         if (ZERO_REG != 0 && addr == '0) word = '0;
         rdata[i*DATA_W +: DATA_W] = word;
         rd_busy[i]                = busy[addr] && !fwd;
      end
   end

   assign stall = |rd_busy;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp at default parameters.
module tb_register_file_mp;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        we_a, we_b, issue_valid;
   logic [4:0]  waddr_a, waddr_b, issue_addr;
   logic [15:0] wdata_a, wdata_b;
   logic [9:0]  raddr;
   logic [31:0] rdata;
   logic [1:0]  rd_busy;
   logic        stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   register_file_mp dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .we_a        (we_a),
      .waddr_a     (waddr_a),
      .wdata_a     (wdata_a),
      .we_b        (we_b),
      .waddr_b     (waddr_b),
      .wdata_b     (wdata_b),
      .raddr       (raddr),
      .rdata       (rdata),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .rd_busy     (rd_busy),
      .stall       (stall)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      we_a = 0; we_b = 0; issue_valid = 0;
      waddr_a = 0; waddr_b = 0; issue_addr = 0;
      wdata_a = 0; wdata_b = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      arst_n = 1'b0;
      idle();
      raddr = {5'd7, 5'd5};
      #12;
      check("reset_rdata0", {16'd0, rdata[15:0]}, 32'h0);
      check("reset_rdata1", {16'd0, rdata[31:16]}, 32'h0);
      check("reset_stall", {31'd0, stall}, 32'h0);
      @(negedge clk);
      arst_n = 1'b1;

      // Write A to 5, forwarded on port 1 in the same cycle.
      next_cycle();
      we_a = 1; waddr_a = 5'd5; wdata_a = 16'h1234; raddr = {5'd5, 5'd0};
      #1 check("fwd_a_rdata1", {16'd0, rdata[31:16]}, 32'h1234);
      next_cycle();
      raddr = {5'd0, 5'd5};
      #1 check("wr_a_rdata0", {16'd0, rdata[15:0]}, 32'h1234);

      // Dual write to 7: B wins in storage and forwarding.
      next_cycle();
      we_a = 1; waddr_a = 5'd7; wdata_a = 16'hAAAA;
      we_b = 1; waddr_b = 5'd7; wdata_b = 16'h5555;
      raddr = {5'd7, 5'd5};
      #1 check("fwd_ab_rdata1", {16'd0, rdata[31:16]}, 32'h5555);
      next_cycle();
      raddr = {5'd5, 5'd7};
      #1 check("wr_ab_rdata0", {16'd0, rdata[15:0]}, 32'h5555);

      // Register 0 is hardwired and never busy.
      next_cycle();
      we_a = 1; waddr_a = 5'd0; wdata_a = 16'hFFFF;
      issue_valid = 1; issue_addr = 5'd0; raddr = {5'd0, 5'd0};
      #1 check("zero_fwd_rdata0", {16'd0, rdata[15:0]}, 32'h0);
      next_cycle();
      raddr = {5'd5, 5'd0};
      #1 check("zero_rdata0", {16'd0, rdata[15:0]}, 32'h0);
      check("zero_rd_busy0", {31'd0, rd_busy[0]}, 32'h0);

      // Busy tracking on register 3.
      next_cycle();
      issue_valid = 1; issue_addr = 5'd3;
      next_cycle();
      raddr = {5'd5, 5'd3};
      #1 check("busy3_rd_busy0", {31'd0, rd_busy[0]}, 32'h1);
      check("busy3_stall", {31'd0, stall}, 32'h1);
      next_cycle();
      we_b = 1; waddr_b = 5'd3; wdata_b = 16'h0042;
      #1 check("fwd3_rd_busy0", {31'd0, rd_busy[0]}, 32'h0);
      check("fwd3_rdata0", {16'd0, rdata[15:0]}, 32'h0042);
      check("fwd3_stall", {31'd0, stall}, 32'h0);
      next_cycle();
      #1 check("clr3_rd_busy0", {31'd0, rd_busy[0]}, 32'h0);
      check("clr3_rdata0", {16'd0, rdata[15:0]}, 32'h0042);

      // Issue and write to 9 together: data lands, busy stays set.
      next_cycle();
      issue_valid = 1; issue_addr = 5'd9;
      we_a = 1; waddr_a = 5'd9; wdata_a = 16'h0099;
      raddr = {5'd9, 5'd5};
      #1 check("iw9_fwd_rdata1", {16'd0, rdata[31:16]}, 32'h0099);
      next_cycle();
      #1 check("iw9_rd_busy1", {31'd0, rd_busy[1]}, 32'h1);
      check("iw9_stall", {31'd0, stall}, 32'h1);
      check("iw9_rdata1", {16'd0, rdata[31:16]}, 32'h0099);
      check("iw9_rd_busy0", {31'd0, rd_busy[0]}, 32'h0);

      // Asynchronous reset mid-cycle.
      next_cycle();
      #2 check("pre_rst_rdata0", {16'd0, rdata[15:0]}, 32'h1234);
      arst_n = 1'b0;
      #1 check("arst_rdata0", {16'd0, rdata[15:0]}, 32'h0);
      check("arst_rdata1", {16'd0, rdata[31:16]}, 32'h0);
      check("arst_stall", {31'd0, stall}, 32'h0);

      // Writes and issues during reset are dropped.
      we_a = 1; waddr_a = 5'd5; wdata_a = 16'hBEEF;
      issue_valid = 1; issue_addr = 5'd5;
      next_cycle();
      @(negedge clk);
      arst_n = 1'b1;
      raddr = {5'd7, 5'd5};
      #1 check("post_rst_rdata0", {16'd0, rdata[15:0]}, 32'h0);
      check("post_rst_rdata1", {16'd0, rdata[31:16]}, 32'h0);
      check("post_rst_busy", {30'd0, rd_busy}, 32'h0);

      // First write after release is accepted.
      next_cycle();
      we_b = 1; waddr_b = 5'd5; wdata_b = 16'hC0DE;
      next_cycle();
      #1 check("post_rst_wr", {16'd0, rdata[15:0]}, 32'hC0DE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, register data width in bits.
REQ-002 The block SHALL have parameter N_REG, default 32, register count (power of two, 2..256).
REQ-003 The block SHALL have parameter N_RD, default 2, number of read ports (1..4).
REQ-004 The block SHALL have parameter ZERO_REG, default 1, which makes register 0 hardwired to zero when 1.
REQ-005 The block SHALL have parameter BYPASS, default 1, which enables same-cycle write-to-read forwarding when 1.
REQ-006 The block SHALL use ADDR_W = clog2(N_REG) as a derived localparam.
REQ-007 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  system clock; arst_n  in  1  asynchronous active-low reset.
REQ-008 The block SHALL have these write port A signals: we_a  in  1  write enable A; waddr_a  in  ADDR_W  write address A; wdata_a  in  DATA_W  write data A.
REQ-009 The block SHALL have these write port B signals: we_b  in  1  write enable B; waddr_b  in  ADDR_W  write address B; wdata_b  in  DATA_W  write data B.
REQ-010 The block SHALL have these read signals: raddr  in  N_RD*ADDR_W  packed read addresses (port i at bits [i*ADDR_W +: ADDR_W]); rdata  out  N_RD*DATA_W  packed read data.
REQ-011 The block SHALL have these scoreboard signals: issue_valid  in  1  mark destination pending; issue_addr  in  ADDR_W  destination register; rd_busy  out  N_RD  per-read-port pending flag; stall  out  1  OR of rd_busy.

Function
REQ-012 Register writes SHALL take effect on the rising clk edge following a cycle with we_x=1; write latency is one cycle.
REQ-013 When both ports write the same address in the same cycle, port B data SHALL be stored.
REQ-014 Reads SHALL be combinational: rdata port i equals register[raddr_i] in the same cycle.
REQ-015 With BYPASS=1, a read whose address matches an active write SHALL return that write data in the same cycle (B over A); with BYPASS=0 it SHALL return the old value.
REQ-016 With ZERO_REG=1, a read of address 0 SHALL return 0, writes to address 0 SHALL be discarded, and register 0 SHALL never be busy.
REQ-017 Each register SHALL have a busy bit that is set on the edge following issue_valid=1 for that address.
REQ-018 A busy bit SHALL be cleared on the edge following a write (A or B) to that address.
REQ-019 When issue and write target the same address in the same cycle, the busy bit SHALL remain set (a new producer wins).
REQ-020 rd_busy[i] SHALL equal busy[raddr_i], except that with BYPASS=1 it SHALL be 0 when a same-cycle write to raddr_i forwards data.
REQ-021 An out-of-range address cannot occur (N_REG is a power of two); no further checking is required.

Reset
REQ-022 While arst_n=0, all registers SHALL be 0 and all busy bits SHALL be 0, asynchronously.
REQ-023 While arst_n=0, rdata SHALL read 0 on all ports (when no bypass is active), rd_busy SHALL be 0 and stall SHALL be 0.
REQ-024 Writes and issues presented during reset SHALL be ignored.
REQ-025 Reset SHALL be released synchronously to clk by the environment; the first write is accepted at the first edge after deassertion.

Structure
REQ-026 A shared package regfile_pkg SHALL hold the clog2 function and the default DATA_W/N_REG constants.
REQ-027 The busy-bit logic SHALL be a sub-module regfile_scoreboard (ports: clk, arst_n, set/set_addr, two clear/clear_addr pairs, busy vector).
REQ-028 The storage SHALL be flip-flops with one always block clocked on posedge clk / negedge arst_n; no latches.

Verification
REQ-029 Reset, then a write_a of addr 5 = 0x1234, then a read of raddr0=5 on the next cycle -> rdata0 = 0x1234.
REQ-030 we_a and we_b both to addr 7 (A=0xAAAA, B=0x5555) -> reg7 = 0x5555; in the same cycle with BYPASS=1, raddr1=7 -> rdata1 = 0x5555.
REQ-031 A write of 0xFFFF to addr 0 with ZERO_REG=1 -> a read of addr 0 = 0x0000; issue to addr 0 -> rd_busy stays 0.
REQ-032 issue addr 3, then raddr0=3 -> rd_busy0=1 and stall=1; write addr 3 = 0x0042 -> same cycle rd_busy0=0 and rdata0=0x0042, next cycle busy cleared.
REQ-033 issue and write of addr 9 in the same cycle -> busy9=1 afterwards and reg9 holds the new data.
REQ-034 Assert arst_n=0 mid-cycle after several writes -> all rdata=0 and stall=0 immediately, before the next clk edge.
